// File: rtl/tpu_host_seq.sv
// tpu_host_seq: bus initiator for one TPU matmul job.
// Streams A rows, B words and C half-rows from the input into the TPU slave
// port, issues the MatMul command, idles for WAIT_CYCLES, then reads the 16 C
// half-rows back out on a valid/ready result stream.
// Build option: define TPU_SEQ_ZERO_C_EN to load C with zeros generated
// internally instead of taking C words from the input stream.
module tpu_host_seq #(
    parameter int DIM         = 8,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             bus_r_w,
    output logic [ADDRW-1:0] bus_addr,
    output logic [DATAW-1:0] bus_wdata,
    input  logic [DATAW-1:0] bus_rdata
);

    localparam int NUM_C = 2 * DIM;                 // C is loaded as half-rows
    localparam int KW    = $clog2(NUM_C);
    localparam int WCW   = $clog2(WAIT_CYCLES + 1);

    localparam logic [ADDRW-1:0] A_BASE   = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_BASE   = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE   = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] CMD_ADDR = ADDRW'(16'h0400);
    localparam logic [ADDRW-1:0] STRIDE   = ADDRW'(DATAW / 8);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, LOAD_C, CMD, WAIT, READ_C
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;        // load word index, reused as readback index j
    logic [WCW-1:0]   wcnt_q;     // 0 = command beat on the bus, 1..WAIT_CYCLES = idle beats
    logic             rw_q;
    logic [ADDRW-1:0] addr_q;
    logic [DATAW-1:0] wdata_q;
    logic             done_q;

    logic             load_fire;
    logic             load_last;
    logic [ADDRW-1:0] load_base;
    logic [DATAW-1:0] load_data;
    state_t           load_next;
    logic [ADDRW-1:0] load_addr_d;
    logic [ADDRW-1:0] rd_addr_d;
    logic             out_hs;

`ifdef TPU_SEQ_ZERO_C_EN
    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
`else
    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);
`endif

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == READ_C);
    assign out_data  = bus_rdata;
    assign done      = done_q;
    assign bus_r_w   = rw_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign out_hs    = out_valid && out_ready;

    assign load_addr_d = load_base + ADDRW'(k_q) * STRIDE;
    assign rd_addr_d   = C_BASE + (ADDRW'(k_q) + ADDRW'(1)) * STRIDE;

    // Per-phase load decode: base address, last-word test, data source, successor
    always_comb begin
        load_base = A_BASE;
        load_last = (k_q == KW'(DIM - 1));
        load_next = LOAD_B;
        load_fire = in_valid && in_ready;
        load_data = in_data;
        case (state_q)
            LOAD_B: begin
                load_base = B_BASE;
                load_next = LOAD_C;
            end
            LOAD_C: begin
                load_base = C_BASE;
                load_last = (k_q == KW'(NUM_C - 1));
                load_next = CMD;
`ifdef TPU_SEQ_ZERO_C_EN
                load_fire = 1'b1;
                load_data = '0;
`endif
            end
            default: ;
        endcase
    end

    // Sequencer FSM; bus outputs fall back to the idle value unless a beat is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            wcnt_q  <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD_A;
                        k_q     <= '0;
                    end
                end
                LOAD_A, LOAD_B, LOAD_C: begin
                    if (load_fire) begin
                        rw_q    <= 1'b1;
                        addr_q  <= load_addr_d;
                        wdata_q <= load_data;
                        if (load_last) begin
                            k_q     <= '0;
                            state_q <= load_next;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                CMD: begin
                    rw_q    <= 1'b1;
                    addr_q  <= CMD_ADDR;
                    wcnt_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (wcnt_q == WCW'(WAIT_CYCLES)) begin
                        addr_q  <= C_BASE;
                        k_q     <= '0;
                        state_q <= READ_C;
                    end else begin
                        wcnt_q <= wcnt_q + WCW'(1);
                    end
                end
                READ_C: begin
                    addr_q <= addr_q;
                    if (out_hs) begin
                        if (k_q == KW'(NUM_C - 1)) begin
                            addr_q  <= '0;
                            k_q     <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            addr_q <= rd_addr_d;
                            k_q    <= k_q + KW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
